// File: rtl/sap_control_sequencer.sv
// SAP-style CPU control sequencer: ring of T-states IDLE, T1-T6, HALTED
// combined with one-hot decoder lines into the datapath control word.
module sap_control_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       lda,
    input  logic       add,
    input  logic       sub,
    input  logic       xor_op,
    input  logic       and_op,
    input  logic       or_op,
    input  logic       cmp_op,
    input  logic       lda_imm,
    input  logic       sta_imm,
    input  logic       out,
    input  logic       low_halt,
    output logic       pc_en,
    output logic       pc_inc,
    output logic       mar_ld,
    output logic       ram_en,
    output logic       ram_wr,
    output logic       ir_ld,
    output logic       ir_en,
    output logic       a_ld,
    output logic       a_en,
    output logic       b_ld,
    output logic       alu_en,
    output logic [2:0] alu_op,
    output logic       flags_ld,
    output logic       out_ld,
    output logic [2:0] t_state,
    output logic       instr_done,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t     state, state_nx;
    logic [9:0] lines, sel;
    logic       done;

    // Isolate the lowest set bit: lda wins over everything down to out.
    assign lines = {out, sta_imm, lda_imm, cmp_op, or_op,
                    and_op, xor_op, sub, add, lda};
    assign sel   = lines & (~lines + 10'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        pc_en    = 1'b0;
        pc_inc   = 1'b0;
        mar_ld   = 1'b0;
        ram_en   = 1'b0;
        ram_wr   = 1'b0;
        ir_ld    = 1'b0;
        ir_en    = 1'b0;
        a_ld     = 1'b0;
        a_en     = 1'b0;
        b_ld     = 1'b0;
        alu_en   = 1'b0;
        alu_op   = 3'b000;
        flags_ld = 1'b0;
        out_ld   = 1'b0;
        done     = 1'b0;
        state_nx = state;
        unique case (state)
            S_IDLE: if (run) state_nx = S_T1;
            S_T1: begin
                pc_en    = 1'b1;
                mar_ld   = 1'b1;
                state_nx = S_T2;
            end
            S_T2: begin
                pc_inc   = 1'b1;
                state_nx = S_T3;
            end
            S_T3: begin
                ram_en   = 1'b1;
                ir_ld    = 1'b1;
                state_nx = S_T4;
            end
            S_T4: begin
                if (!low_halt) begin
                    state_nx = S_HALT;
                end else begin
                    unique case (1'b1)
                        sel[0], sel[1], sel[2], sel[3],
                        sel[4], sel[5], sel[6], sel[8]: begin
                            ir_en    = 1'b1;
                            mar_ld   = 1'b1;
                            state_nx = S_T5;
                        end
                        sel[7]: begin
                            ir_en = 1'b1;
                            a_ld  = 1'b1;
                            done  = 1'b1;
                        end
                        sel[9]: begin
                            a_en   = 1'b1;
                            out_ld = 1'b1;
                            done   = 1'b1;
                        end
                        default: done = 1'b1;
                    endcase
                end
            end
            S_T5: begin
                unique case (1'b1)
                    sel[0]: begin
                        ram_en = 1'b1;
                        a_ld   = 1'b1;
                        done   = 1'b1;
                    end
                    sel[1], sel[2], sel[3],
                    sel[4], sel[5], sel[6]: begin
                        ram_en   = 1'b1;
                        b_ld     = 1'b1;
                        state_nx = S_T6;
                    end
                    sel[8]: begin
                        a_en   = 1'b1;
                        ram_wr = 1'b1;
                        done   = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            S_T6: begin
                done = 1'b1;
                unique case (1'b1)
                    sel[1], sel[2], sel[3], sel[4], sel[5]: begin
                        alu_en   = 1'b1;
                        a_ld     = 1'b1;
                        flags_ld = 1'b1;
                        alu_op   = sel[2] ? 3'b001 :
                                   sel[3] ? 3'b010 :
                                   sel[4] ? 3'b011 :
                                   sel[5] ? 3'b100 : 3'b000;
                    end
                    // Compare: subtract for flags only, A untouched.
                    sel[6]: begin
                        alu_op   = 3'b001;
                        flags_ld = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
        if (done) state_nx = run ? S_T1 : S_IDLE;
    end

    assign instr_done = done;
    assign halted     = (state == S_HALT);
    assign t_state    = state;

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Ring-counter control sequencer for the 8-bit SAP-style CPU. It steps the machine through fetch states T1–T3 and execute states T4–T6, and combines the current T-state with the one-hot opcode lines from the instruction decoder to drive the datapath control word. Instruction length is variable: an instruction returns to T1 as soon as its last useful state completes. The block sits between the instruction decoder and the PC, MAR, RAM, IR, A, B, ALU, flags and output registers.

## Interface
- No parameters; T-state count fixed at 6.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level. Permits fetch of the next instruction.
- `lda`, `add`, `sub`, `xor_op`, `and_op`, `or_op`, `cmp_op`, `lda_imm`, `sta_imm`, `out` in 1 each: one-hot decoder lines (opcodes 0000–1000, 1110).
- `low_halt` in 1: decoder halt line, low for opcode 1111.
- `pc_en` out 1: PC drives bus.
- `pc_inc` out 1: PC increments.
- `mar_ld` out 1: MAR loads from bus.
- `ram_en` out 1: RAM drives bus.
- `ram_wr` out 1: RAM writes bus data at MAR.
- `ir_ld` out 1: IR loads.
- `ir_en` out 1: IR operand nibble drives bus.
- `a_ld`, `a_en` out 1 each: A load, A drives bus.
- `b_ld` out 1: B loads.
- `alu_en` out 1: ALU result drives bus.
- `alu_op` out 3: 000 add, 001 sub, 010 xor, 011 and, 100 or.
- `flags_ld` out 1: flag register loads.
- `out_ld` out 1: output register loads.
- `t_state` out 3: 0 = IDLE, 1–6 = T1–T6, 7 = HALTED.
- `instr_done` out 1: high during the final T-state of each instruction.
- `halted` out 1: high in HALTED.

## Operation
- States are IDLE, T1–T6 and HALTED. Controls are decoded combinationally from the registered state and the decoder lines. All unlisted controls are 0, and `alu_op` is 000.
- IDLE: all controls 0. Go to T1 if `run`=1, else stay in IDLE.
- T1: `pc_en`, `mar_ld`. Go to T2.
- T2: `pc_inc`. Go to T3.
- T3: `ram_en`, `ir_ld`. Go to T4.
- T4, by opcode:
  - lda, ALU ops, cmp, sta_imm: `ir_en`, `mar_ld`; go to T5.
  - lda_imm: `ir_en`, `a_ld`; done.
  - out: `a_en`, `out_ld`; done.
  - `low_halt`=0: no controls; go to HALTED.
  - No line asserted (opcodes 1001–1101): NOP, no controls; done.
- T5, by opcode:
  - lda: `ram_en`, `a_ld`; done.
  - add/sub/xor/and/or/cmp: `ram_en`, `b_ld`; go to T6.
  - sta_imm: `a_en`, `ram_wr`; done.
- T6, by opcode:
  - add/sub/xor/and/or: `alu_en`, `a_ld`, `flags_ld`, `alu_op` per opcode; done.
  - cmp: `alu_op`=001, `flags_ld` only; A is unchanged; done.
- "done": `instr_done`=1 during that state. Next state is T1 if `run`=1, else IDLE.
- `run` dropping mid-instruction does not abort the instruction. It is sampled only at done.
- HALTED is sticky and all controls are 0. Only `rst_n` exits it.
- Multiple decoder lines asserted is a decoder fault. Priority is lda > add > sub > xor > and > or > cmp > lda_imm > sta_imm > out; halt overrides all.

## Timing
- Reset: state IDLE, all outputs 0, `t_state`=0, `halted`=0. Reset takes effect immediately (asynchronous), including mid-instruction. Release is synchronous to the next edge.
- A control asserted in state Tn is captured by its target on the rising edge that ends Tn.
- Instruction lengths in cycles:

  | Instruction | Cycles |
  |---|---|
  | NOP, out, lda_imm | 4 (NOP ends after T4) |
  | lda, sta_imm | 5 |
  | ALU ops, cmp | 6 |
  | halt | reaches HALTED on the edge ending T4 |

- Back-to-back: with `run`=1, the state after done is T1, with no idle cycle.
- From IDLE, T1 begins one cycle after `run` is sampled high.
- Decoder lines are valid from T4 onward, because IR loads at the end of T3. Decoder values during T1–T3 are ignored.

## Test plan
- Reset then `run`=1, opcode lda: `t_state` 1,2,3,4,5,1. T1 shows `pc_en`+`mar_ld`, T3 shows `ir_ld`, T5 shows `ram_en`+`a_ld` with `instr_done`=1.
- xor_op then cmp_op back-to-back: xor T6 has `alu_en`,`a_ld`,`flags_ld`,`alu_op`=010. cmp T6 has `flags_ld`=1,`a_ld`=0,`alu_op`=001. The next T1 follows immediately.
- out with `run` dropped during T2: instruction completes (T4 `a_en`+`out_ld`), then IDLE. Re-asserting `run` gives T1 one cycle later.
- Opcode 1111: after T4, `halted`=1 and `t_state`=7. It holds for 20 cycles with `run`=1 and all controls 0. `rst_n` low returns to IDLE.
- `rst_n` pulsed low during T5 of add: outputs go to 0 without waiting for a clock edge. No `b_ld` is issued, and the state is IDLE.
- Opcode 1010 (no line asserted): T4 has no controls and `instr_done`=1. sta_imm T5 has `a_en`+`ram_wr`, length 5.
